// File: rtl/ifu_prefetch.sv
// -----------------------------------------------------------------------------
// ifu_prefetch
//
// Instruction prefetch stage. Owns the program counter, drives the instruction
// SRAM request port, captures the returned word one cycle later and buffers
// {pc, ins} pairs in a small FIFO that feeds the execute stage through a
// valid/ready handshake. A redirect from execute flushes the FIFO, discards the
// response that lands in the redirect cycle, and fetches the target in that
// same cycle.
//
// Parameters:
//   PC_W     - PC / SRAM byte-address width (default 16)
//   RESET_PC - first fetch address after reset (default 16'h0000)
//   DEPTH    - FIFO entries, at least 2 for one instruction per cycle
//
// Ports:
//   clk      in   1     rising-edge clock
//   rstn     in   1     asynchronous active-low reset
//   ins_a    out  PC_W  fetch byte address, bits [1:0] always 0
//   ins_e    out  1     fetch request (combinational)
//   ins      in   32    SRAM read data, valid the cycle after ins_e
//   br_e     in   1     redirect request from execute
//   br_pc    in   PC_W  redirect target, bits [1:0] ignored
//   ifu_vld  out  1     head entry valid
//   ifu_pc   out  PC_W  head PC (0 while not valid)
//   ifu_ins  out  32    head instruction word (0 while not valid)
//   ifu_rdy  in   1     execute accepts the head this cycle
//
// Configuration macro:
//   IFU_PREFETCH_BYPASS_EN - when defined, a response arriving while the FIFO
//   is empty is presented combinationally on ifu_* in its arrival cycle and is
//   only written into the FIFO if it is not consumed there. Fetch latency and
//   redirect penalty both drop from 2 to 1. When undefined, ifu_* come from
//   FIFO storage only.
// -----------------------------------------------------------------------------
module ifu_prefetch #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rstn,
  output logic [PC_W-1:0] ins_a,
  output logic            ins_e,
  input  logic [31:0]     ins,
  input  logic            br_e,
  input  logic [PC_W-1:0] br_pc,
  output logic            ifu_vld,
  output logic [PC_W-1:0] ifu_pc,
  output logic [31:0]     ifu_ins,
  input  logic            ifu_rdy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     ins;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             run;       // 0 during the first cycle after reset release
  logic [PC_W-1:0]  pc;        // next sequential fetch address
  logic [PC_W-1:0]  req_pc;    // address of the request issued last cycle
  logic             inflight;  // a response is on `ins` this cycle

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic             redirect;
  logic             kill;      // response arriving this cycle must be dropped
  logic             byp;       // head is taken straight from the SRAM response
  logic             fifo_empty;
  logic             pop;       // execute consumes the head
  logic             pop_fifo;  // ... and the head came from FIFO storage
  logic             push;
  logic             credit;
  logic             issue;
  logic [CNT_W:0]   used;
  logic [PC_W-1:0]  target;
  entry_t           head;

  // br_pc[1:0] is deliberately dropped: fetches are word aligned.
  logic             unused_br_lsb;
  assign unused_br_lsb = ^br_pc[1:0];

  assign target     = {br_pc[PC_W-1:2], 2'b00};
  assign redirect   = run & br_e;
  assign fifo_empty = (count == '0);

  // The only response that can be in flight during a redirect is the one
  // landing in the redirect cycle itself (it belongs to the old path). The
  // target request issued in that cycle must be kept, so the discard applies
  // to the current cycle only.
  assign kill = redirect;

`ifdef IFU_PREFETCH_BYPASS_EN
  // Depends only on registered state, so ifu_vld never combinationally
  // depends on br_e or ifu_rdy.
  assign byp = fifo_empty & inflight;
`else
  assign byp = 1'b0;
`endif

  // Head selection. Outputs are forced to zero while nothing is valid so the
  // un-reset FIFO storage never leaks onto the bus.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    head    = mem[rd_ptr];
    ifu_vld = ~fifo_empty;
    if (byp) begin
      head.pc  = req_pc;
      head.ins = ins;
      ifu_vld  = 1'b1;
    end
  end

  assign ifu_pc  = ifu_vld ? head.pc  : '0;
  assign ifu_ins = ifu_vld ? head.ins : '0;

  // A redirect takes priority over consumption of the head.
  assign pop      = ifu_vld & ifu_rdy & ~br_e;
  assign pop_fifo = pop & ~byp;

  // A bypassed response that is consumed immediately never occupies storage.
  assign push = inflight & ~kill & ~(byp & pop);

  // Credit: entries held plus the response in flight, less the one leaving
  // this cycle, must stay below DEPTH for a new request to be safe. pop can
  // only be 1 when count or inflight is non-zero, so this never underflows.
  assign used   = {1'b0, count}
                + {{CNT_W{1'b0}}, inflight}
                - {{CNT_W{1'b0}}, pop};
  assign credit = (used < (CNT_W + 1)'(DEPTH));
  assign issue  = run & credit;

  // Request port. A redirect always issues: the flush frees every entry.
  always_comb begin
    ins_e = 1'b0;
    ins_a = pc;
    if (redirect) begin
      ins_e = 1'b1;
      ins_a = target;
    end else if (issue) begin
      ins_e = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch-side registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run      <= 1'b0;
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      run      <= 1'b1;
      inflight <= ins_e;
      if (ins_e) begin
        req_pc <= ins_a;
        // PC arithmetic wraps modulo 2^PC_W.
        pc     <= ins_a + PC_W'(4);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // ---------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)     wr_ptr <= ptr_inc(wr_ptr);
      if (pop_fifo) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop_fifo);
    end
  end

  // NOTE: the storage array has no reset; an entry is only observable once
  // count says it was written, and the output mux zeroes ifu_* otherwise.
  // Writing into the slot being popped when full is safe: the read is
  // combinational in this cycle, the write lands at the edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr].pc  <= req_pc;
      mem[wr_ptr].ins <= ins;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// -----------------------------------------------------------------------------
// tb_ifu_prefetch
//
// Self-checking bench for ifu_prefetch. The reference model tracks, as a
// queue, every fetch issued since the last flush together with the cycle it
// was issued in. From that queue it derives what the handshake must show:
// the head is valid once its fetch latency has elapsed, its PC/word come from
// the SRAM contents, a request may issue only while fewer than DEPTH fetches
// are outstanding, and a redirect empties the queue and fetches the target.
// A second instance with RESET_PC = 16'hFFF8 checks PC wrap-around.
// -----------------------------------------------------------------------------
module tb_ifu_prefetch;

  localparam int PC_W  = 16;
  localparam int DEPTH = 2;
`ifdef IFU_PREFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk     = 1'b0;
  logic        rstn    = 1'b0;
  logic        br_e    = 1'b0;
  logic [15:0] br_pc   = '0;
  logic        ifu_rdy = 1'b0;
  logic        one     = 1'b1;
  logic        zero    = 1'b0;
  logic [15:0] zero16  = '0;

  logic [15:0] ins_a;
  logic        ins_e;
  logic [31:0] ins_q = '0;
  logic        ifu_vld;
  logic [15:0] ifu_pc;
  logic [31:0] ifu_ins;

  logic [15:0] ins_a2;
  logic        ins_e2;
  logic [31:0] ins_q2 = '0;
  logic        vld2;
  logic [15:0] pc2;
  logic [31:0] iw2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ifu_prefetch #(.PC_W(PC_W), .RESET_PC(16'h0000), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .ins_a(ins_a), .ins_e(ins_e), .ins(ins_q),
    .br_e(br_e), .br_pc(br_pc),
    .ifu_vld(ifu_vld), .ifu_pc(ifu_pc), .ifu_ins(ifu_ins), .ifu_rdy(ifu_rdy)
  );

  ifu_prefetch #(.PC_W(PC_W), .RESET_PC(16'hFFF8), .DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rstn(rstn),
    .ins_a(ins_a2), .ins_e(ins_e2), .ins(ins_q2),
    .br_e(zero), .br_pc(zero16),
    .ifu_vld(vld2), .ifu_pc(pc2), .ifu_ins(iw2), .ifu_rdy(one)
  );

  // SRAM contents: two fixed words at 0 and 4, a recognisable pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 32'h0000_0013;
    if (a == 16'h0004) return 32'h0010_0093;
    return {a ^ 16'hA5A5, a};
  endfunction

  // Synchronous SRAMs: data valid the cycle after the request.
  always @(posedge clk) begin
    if (ins_e)  ins_q  <= mem_word(ins_a);
    if (ins_e2) ins_q2 <= mem_word(ins_a2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and per-cycle compare (outputs sampled on the falling edge)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [15:0] pc;
    int          t;
  } req_t;

  req_t        q[$];
  logic [15:0] fetch_pc = 16'h0000;
  int          cyc = 0;
  logic        m_run = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) m_run <= 1'b0;
    else       m_run <= 1'b1;
  end

  always @(negedge clk) begin : compare
    logic        exp_vld;
    logic        do_pop;
    logic        redir;
    logic        exp_e;
    logic [15:0] exp_a;
    req_t        r;
    if (!rstn) begin
      check("rst_ins_e",   {31'd0, ins_e},   32'd0);
      check("rst_ins_a",   {16'd0, ins_a},   32'h0000);
      check("rst_ifu_vld", {31'd0, ifu_vld}, 32'd0);
      check("rst_ifu_pc",  {16'd0, ifu_pc},  32'd0);
      check("rst_ifu_ins", ifu_ins,          32'd0);
      q.delete();
      fetch_pc = 16'h0000;
      cyc      = 0;
    end else begin
      cyc++;
      exp_vld = (q.size() > 0) && (cyc - q[0].t >= LAT);
      do_pop  = exp_vld && ifu_rdy && !br_e;
      redir   = m_run && br_e;
      if (redir) begin
        exp_e = 1'b1;
        exp_a = {br_pc[15:2], 2'b00};
      end else begin
        exp_e = m_run && ((int'(q.size()) - int'(do_pop)) < DEPTH);
        exp_a = fetch_pc;
      end

      check("ins_e",   {31'd0, ins_e},   {31'd0, exp_e});
      if (exp_e) check("ins_a", {16'd0, ins_a}, {16'd0, exp_a});
      check("ifu_vld", {31'd0, ifu_vld}, {31'd0, exp_vld});
      if (exp_vld) begin
        check("ifu_pc",  {16'd0, ifu_pc}, {16'd0, q[0].pc});
        check("ifu_ins", ifu_ins,         mem_word(q[0].pc));
      end

      if (redir)       q.delete();
      else if (do_pop) void'(q.pop_front());
      if (exp_e) begin
        r.pc = exp_a;
        r.t  = cyc;
        q.push_back(r);
        fetch_pc = exp_a + 16'd4;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  logic [15:0] wrap_exp [4];

  initial begin
    wrap_exp[0] = 16'hFFF8;
    wrap_exp[1] = 16'hFFFC;
    wrap_exp[2] = 16'h0000;
    wrap_exp[3] = 16'h0004;

    // Reset, then release with the consumer always ready.
    rstn    = 1'b0;
    ifu_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;                                   // cycle R
    @(negedge clk);
    check("R_ins_e", {31'd0, ins_e}, 32'd0);
    @(negedge clk);                                   // R+1 = C0
    check("C0_ins_e", {31'd0, ins_e}, 32'd1);
    check("C0_ins_a", {16'd0, ins_a}, 32'h0000);
    repeat (LAT) @(negedge clk);                      // first valid
    check("first_vld", {31'd0, ifu_vld}, 32'd1);
    check("first_pc",  {16'd0, ifu_pc},  32'h0000);
    check("first_ins", ifu_ins,          32'h0000_0013);
    check("wrap_pc0",  {16'd0, pc2},     {16'd0, wrap_exp[0]});

    // Streaming: 20 consecutive PCs, no gaps.
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      check("stream_vld", {31'd0, ifu_vld}, 32'd1);
      check("stream_pc",  {16'd0, ifu_pc},  32'(i * 4));
      if (i == 1) check("second_ins", ifu_ins, 32'h0010_0093);
      if (i < 4)  check("wrap_pc", {16'd0, pc2}, {16'd0, wrap_exp[i]});
    end

    // Stall for 5 cycles: FIFO fills, requests stop.
    @(posedge clk); #1 ifu_rdy = 1'b0;
    repeat (5) @(negedge clk);
    check("stall_ins_e", {31'd0, ins_e},   32'd0);
    check("stall_vld",   {31'd0, ifu_vld}, 32'd1);
    check("stall_pc",    {16'd0, ifu_pc},  32'h0050);
    @(posedge clk); #1 ifu_rdy = 1'b1;
    @(negedge clk);
    check("resume_ins_e", {31'd0, ins_e}, 32'd1);
    @(negedge clk);
    check("resume_pc", {16'd0, ifu_pc}, 32'h0054);

    // Redirect while streaming.
    repeat (3) @(posedge clk);
    #1 br_e = 1'b1; br_pc = 16'h0103;
    @(negedge clk);
    check("br_ins_e", {31'd0, ins_e}, 32'd1);
    check("br_ins_a", {16'd0, ins_a}, 32'h0100);
    @(posedge clk); #1 br_e = 1'b0;
    repeat (LAT) @(negedge clk);
    check("br_tgt_vld", {31'd0, ifu_vld}, 32'd1);
    check("br_tgt_pc",  {16'd0, ifu_pc},  32'h0100);
    check("br_tgt_ins", ifu_ins,          mem_word(16'h0100));

    // Random traffic: back-pressure, redirects, targets near the top of memory.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      ifu_rdy = ($urandom_range(0, 9) < 7);
      br_e    = ($urandom_range(0, 19) == 0);
      br_pc   = ($urandom_range(0, 3) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                            : 16'($urandom);
    end

    // Reset pulse while fetches are in flight.
    @(posedge clk); #1 br_e = 1'b0; ifu_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    check("async_rst_vld",  {31'd0, ifu_vld}, 32'd0);
    check("async_rst_ins_e", {31'd0, ins_e},  32'd0);
    check("async_rst_pc",   {16'd0, ifu_pc},  32'd0);
    @(posedge clk); #1 rstn = 1'b1;                   // new cycle R
    repeat (2 + LAT) @(negedge clk);
    check("restart_vld", {31'd0, ifu_vld}, 32'd1);
    check("restart_pc",  {16'd0, ifu_pc},  32'h0000);
    @(negedge clk);
    check("restart_pc1", {16'd0, ifu_pc},  32'h0004);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
